ahb_slave_regfile: RTL

- AHB-style slave forming the responder end of the team's AHB master link.
- Decodes address/data phases and holds a 16 x 32-bit register file.
- Inserts a programmable number of wait states, and returns a two-cycle ERROR response on illegal writes.
- Sits directly on the master's HADDR/HWRITE/write-data bus; its HREADY output feeds the master's HREADY input.

---
 rtl/ahb_pkg.sv | 25 ++
 rtl/ahb_slave_mem.sv | 37 +++
 rtl/ahb_slave_regfile.sv | 117 +++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB types and constants for the register-file slave.
// Transfer encodings, response codes, slave FSM states and the ID register address.
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

    localparam logic [3:0] ID_ADDR = 4'hF;

endpackage

// File: rtl/ahb_slave_mem.sv
// Register storage for the AHB slave: writable entries below the top address,
// with the top address read back as a constant ID value.
module ahb_slave_mem #(
    parameter int unsigned          ADDR_W   = 4,
    parameter int unsigned          DATA_W   = 32,
    parameter logic [DATA_W-1:0]    ID_VALUE = 32'hA5B0_0001
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned     DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    logic [DATA_W-1:0] r_mem [DEPTH-1];
    logic              w_id_rd;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != TOP_ADDR)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The top address has no storage behind it; it always reads as the ID constant.
    assign w_id_rd = (i_raddr == TOP_ADDR);
    assign o_rdata = w_id_rd ? ID_VALUE : r_mem[i_raddr];

endmodule

// File: rtl/ahb_slave_regfile.sv
// AHB slave with a 16-entry register file, programmable wait states and a
// two-cycle ERROR response for writes to the read-only ID register.
module ahb_slave_regfile
    import ahb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 4,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADY,
    output logic              HRESP
);

    slv_state_t        r_state, w_state_next;
    logic [2:0]        r_cnt, w_cnt_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic              r_write, w_write_next;
    logic              r_err, w_err_next;
    logic              w_req;
    logic              w_new_err;
    logic              w_we;
    logic [DATA_W-1:0] w_mem_rdata;
    htrans_t           w_trans;

    assign w_trans   = htrans_t'(HTRANS);
    assign w_req     = HSEL && ((w_trans == TRANS_NONSEQ) || (w_trans == TRANS_SEQ));
    assign w_new_err = HWRITE && (HADDR == ADDR_W'(ID_ADDR));

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_addr;
        w_write_next = r_write;
        w_err_next   = r_err;
        HREADY       = 1'b1;
        HRESP        = HRESP_OKAY;

        unique case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                HREADY       = 1'b1;
                HRESP        = (r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
                w_state_next = ST_IDLE;
                // HREADY is high in all three states, so a request here is accepted.
                if (w_req) begin
                    w_addr_next  = HADDR;
                    w_write_next = HWRITE;
                    w_err_next   = w_new_err;
                    if (WAIT_STATES > 0) begin
                        w_state_next = ST_WAIT;
                        w_cnt_next   = 3'(WAIT_STATES - 1);
                    end else begin
                        w_state_next = w_new_err ? ST_ERR1 : ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                HREADY = 1'b0;
                if (r_cnt != 3'd0) begin
                    w_cnt_next = r_cnt - 3'd1;
                end else begin
                    w_state_next = r_err ? ST_ERR1 : ST_DATA;
                end
            end
            ST_ERR1: begin
                HREADY       = 1'b0;
                HRESP        = HRESP_ERROR;
                w_state_next = ST_ERR2;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
            r_write <= w_write_next;
            r_err   <= w_err_next;
        end
    end

    assign w_we   = (r_state == ST_DATA) && r_write;
    assign HRDATA = ((r_state == ST_DATA) && !r_write) ? w_mem_rdata : '0;

    ahb_slave_mem #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .ID_VALUE (ID_VALUE)
    ) u_mem (
        .i_clk   (HCLK),
        .i_rst_n (HRESETn),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (HWDATA),
        .i_raddr (r_addr),
        .o_rdata (w_mem_rdata)
    );

endmodule
